// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the byte-wise fetch unit and its instruction queue.
// No logic: default widths, byte-lane indices and the word-assembly state encoding.
package fetch_queue_pkg;

  localparam int IQ_DEPTH_DEF = 4;
  localparam int IQ_PTR_W_DEF = 2;
  localparam int ADDR_W_DEF   = 32;
  localparam int INST_W_DEF   = 32;

  localparam int BYTE_W = 8;
  localparam int BYTE_0 = 0;
  localparam int BYTE_1 = 1;
  localparam int BYTE_2 = 2;
  localparam int BYTE_3 = 3;

  // Which byte lane of the word the next returning byte fills.
  typedef enum logic [1:0] {
    ASM_B0 = 2'd0,
    ASM_B1 = 2'd1,
    ASM_B2 = 2'd2,
    ASM_B3 = 2'd3
  } asm_state_t;

endpackage

// File: rtl/iq_fifo.sv
// FWFT queue of pc+instruction entries; head visible the cycle after the push.
// Backpressure is the caller's job (no overflow guard); flush clears pointers and count.
module iq_fifo #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head_dat,
  output logic [PTR_W:0]    count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Prefetches bytes, assembles LE 32-bit words into a FWFT queue; first word 5 cycles after first grant.
// Requests stop while the queue is full or rdy_in is low; a granted byte is always captured.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_DEPTH_DEF,
  parameter int IQ_PTR_W = IQ_PTR_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INST_W   = INST_W_DEF
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                change_pc_in,
  input  logic [ADDR_W-1:0]   next_pc_in,
  input  logic                mem_grant_in,
  input  logic [BYTE_W-1:0]   mem_byte_in,
  output logic                req_valid_out,
  output logic [ADDR_W-1:0]   req_addr_out,
  output logic                inst_valid_out,
  output logic [INST_W-1:0]   inst_out,
  output logic [ADDR_W-1:0]   pc_out,
  input  logic                inst_ready_in,
  output logic [IQ_PTR_W:0]   iq_count_out
);

  localparam int ENTRY_W = ADDR_W + INST_W;

  asm_state_t            byte_cnt;
  logic [ADDR_W-1:0]     fpc;
  logic [ADDR_W-1:0]     asm_pc;
  logic [3*BYTE_W-1:0]   asm_buf;
  logic                  pending;
  logic                  grant;
  logic                  capture;
  logic                  push;
  logic                  pop;
  logic [IQ_PTR_W:0]     count;
  logic [ENTRY_W-1:0]    push_dat;
  logic [ENTRY_W-1:0]    head_dat;

  assign req_valid_out  = rdy_in & ~change_pc_in & (count < (IQ_PTR_W+1)'(IQ_DEPTH));
  assign req_addr_out   = fpc;
  assign grant          = req_valid_out & mem_grant_in;
  assign capture        = pending & ~change_pc_in;
  assign push           = capture & (byte_cnt == ASM_B3);
  assign inst_valid_out = (count != '0) & rdy_in;
  assign pop            = inst_valid_out & inst_ready_in;
  assign push_dat       = {asm_pc, INST_W'({mem_byte_in, asm_buf})};
  assign inst_out       = head_dat[INST_W-1:0];
  assign pc_out         = head_dat[ENTRY_W-1:INST_W];
  assign iq_count_out   = count;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fpc      <= '0;
      byte_cnt <= ASM_B0;
      asm_buf  <= '0;
      asm_pc   <= '0;
      pending  <= 1'b0;
    end else if (change_pc_in) begin
      fpc      <= next_pc_in;
      byte_cnt <= ASM_B0;
      pending  <= 1'b0;
    end else begin
      pending <= grant;
      if (grant) fpc <= fpc + ADDR_W'(1);
      if (capture) begin
        // fpc already points past the byte now returning
        case (byte_cnt)
          ASM_B0: begin
            asm_buf[BYTE_0*BYTE_W +: BYTE_W] <= mem_byte_in;
            asm_pc   <= fpc - ADDR_W'(1);
            byte_cnt <= ASM_B1;
          end
          ASM_B1: begin
            asm_buf[BYTE_1*BYTE_W +: BYTE_W] <= mem_byte_in;
            byte_cnt <= ASM_B2;
          end
          ASM_B2: begin
            asm_buf[BYTE_2*BYTE_W +: BYTE_W] <= mem_byte_in;
            byte_cnt <= ASM_B3;
          end
          ASM_B3: begin
            byte_cnt <= ASM_B0;
          end
          default: byte_cnt <= ASM_B0;
        endcase
      end
    end
  end

  iq_fifo #(
    .DEPTH  (IQ_DEPTH),
    .PTR_W  (IQ_PTR_W),
    .DATA_W (ENTRY_W)
  ) u_iq_fifo (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .flush    (change_pc_in),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: bench plays memory/arbiter and decode, expected values hand-computed.
module tb_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        change_pc_in;
  logic [31:0] next_pc_in;
  logic        mem_grant_in;
  logic [7:0]  mem_byte_in;
  logic        req_valid_out;
  logic [31:0] req_addr_out;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_ready_in;
  logic [2:0]  iq_count_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

  fetch_queue dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .change_pc_in   (change_pc_in),
    .next_pc_in     (next_pc_in),
    .mem_grant_in   (mem_grant_in),
    .mem_byte_in    (mem_byte_in),
    .req_valid_out  (req_valid_out),
    .req_addr_out   (req_addr_out),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_ready_in  (inst_ready_in),
    .iq_count_out   (iq_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Memory image: program bytes at 0..7, elsewhere the low address byte.
  function automatic logic [7:0] mem_at(input logic [31:0] a);
    if (a < 32'd8) return prog[a[2:0]];
    return a[7:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: record this cycle's handshake, then return the granted byte next cycle.
  task automatic tick(input int n);
    logic        gnt;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      #1;
      gnt = req_valid_out & mem_grant_in;
      a   = req_addr_out;
      @(posedge clk_in);
      #1;
      mem_byte_in = gnt ? mem_at(a) : 8'hEE;
    end
  endtask

  task automatic do_reset();
    rst_n_in      = 1'b0;
    rdy_in        = 1'b0;
    change_pc_in  = 1'b0;
    next_pc_in    = '0;
    mem_grant_in  = 1'b0;
    mem_byte_in   = 8'h00;
    inst_ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_req_valid", req_valid_out, 0);
    check("rst_req_addr", req_addr_out, 0);
    check("rst_inst_valid", inst_valid_out, 0);
    check("rst_inst", inst_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_count", iq_count_out, 0);

    // Continuous grants, decode stalled: first word latency, then fill to full
    rdy_in = 1'b1; mem_grant_in = 1'b1; inst_ready_in = 1'b0;
    tick(4);
    check("lat_not_yet", inst_valid_out, 0);
    tick(1);
    check("first_valid", inst_valid_out, 1);
    check("first_inst", inst_out, 32'h00000013);
    check("first_pc", pc_out, 0);
    check("first_count", iq_count_out, 1);
    tick(4);
    check("second_count", iq_count_out, 2);
    tick(8);
    // Word 3 pushes while count=3, so byte 16 is still granted alongside it
    check("full_count", iq_count_out, 4);
    check("full_req_drop", req_valid_out, 0);
    check("full_addr", req_addr_out, 32'h11);
    tick(2);
    check("full_addr_hold", req_addr_out, 32'h11);
    check("full_count_hold", iq_count_out, 4);

    inst_ready_in = 1'b1;
    tick(1);
    check("pop1_count", iq_count_out, 3);
    check("pop1_inst", inst_out, 32'h00100093);
    check("pop1_pc", pc_out, 4);
    check("pop1_req_resume", req_valid_out, 1);
    tick(1);
    check("pop2_count", iq_count_out, 2);
    check("pop2_inst", inst_out, 32'h0B0A0908);
    check("pop2_pc", pc_out, 8);
    check("pop2_addr", req_addr_out, 32'h12);

    // Pop and fourth-byte push in the same cycle
    inst_ready_in = 1'b0;
    tick(2);
    inst_ready_in = 1'b1;
    tick(1);
    check("pp_count", iq_count_out, 2);
    check("pp_inst", inst_out, 32'h0F0E0D0C);
    check("pp_pc", pc_out, 12);
    tick(1);
    check("pp_next_count", iq_count_out, 1);
    check("pp_next_inst", inst_out, 32'h13121110);
    check("pp_next_pc", pc_out, 16);
    inst_ready_in = 1'b0;

    // Grant on alternate cycles only
    do_reset();
    rdy_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_grant_in = ~i[0];
      tick(1);
      if (i == 2) check("alt_fpc_mid", req_addr_out, 2);
    end
    check("alt_count", iq_count_out, 1);
    check("alt_inst", inst_out, 32'h00000013);
    check("alt_pc", pc_out, 0);
    check("alt_fpc", req_addr_out, 4);

    // Flush with a half-built word and two queued entries
    do_reset();
    rdy_in = 1'b1; mem_grant_in = 1'b1;
    tick(11);
    check("pre_flush_count", iq_count_out, 2);
    change_pc_in = 1'b1; next_pc_in = 32'h1000;
    #1;
    check("flush_no_req", req_valid_out, 0);
    tick(1);
    change_pc_in = 1'b0;
    check("flush_count", iq_count_out, 0);
    check("flush_valid", inst_valid_out, 0);
    check("flush_addr", req_addr_out, 32'h1000);
    tick(5);
    check("post_flush_count", iq_count_out, 1);
    check("post_flush_inst", inst_out, 32'h03020100);
    check("post_flush_pc", pc_out, 32'h1000);

    // rdy_in drops right after a grant
    do_reset();
    rdy_in = 1'b1; mem_grant_in = 1'b1;
    tick(1);
    rdy_in = 1'b0;
    #1;
    check("rdy_no_req", req_valid_out, 0);
    tick(2);
    check("rdy_fpc_hold", req_addr_out, 1);
    check("rdy_req_low", req_valid_out, 0);
    rdy_in = 1'b1;
    tick(4);
    rdy_in = 1'b0;
    #1;
    check("rdy_valid_gated", inst_valid_out, 0);
    check("rdy_count", iq_count_out, 1);
    rdy_in = 1'b1;
    #1;
    check("rdy_valid", inst_valid_out, 1);
    check("rdy_inst", inst_out, 32'h00000013);
    check("rdy_pc", pc_out, 0);

    // Redirect near the top of the address space: fpc wraps to 0
    change_pc_in = 1'b1; next_pc_in = 32'hFFFF_FFFE;
    tick(1);
    change_pc_in = 1'b0;
    tick(5);
    check("wrap_count", iq_count_out, 1);
    check("wrap_inst", inst_out, 32'h0013FFFE);
    check("wrap_pc", pc_out, 32'hFFFF_FFFE);
    check("wrap_fpc", req_addr_out, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
